// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and types
package uart_pkg;

  // Increments for 16x oversampling of 115200 baud
  localparam int UART_INC_100M_115200 = 151;  // ACC_WIDTH 13
  localparam int UART_INC_66M_115200  = 453;  // ACC_WIDTH 14

  // Default log2 of oversample ticks per bit
  localparam int UART_OS_LOG2_DEFAULT = 4;

  // Phase counter at the default oversample ratio
  typedef logic [UART_OS_LOG2_DEFAULT-1:0] uart_phase_t;

endpackage

// File: rtl/uart_tick_div.sv
// rtl/uart_tick_div.sv - modulo-2^WIDTH phase counter with terminal and mid-count decode
module uart_tick_div #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             count_en,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             mid
);

  localparam logic [WIDTH-1:0] MID_COUNT = WIDTH'((1 << (WIDTH - 1)) - 1);

  // Counter wraps naturally at 2^WIDTH; clear returns it to zero phase
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal = &count;
  assign mid      = (count == MID_COUNT);

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional-N baud tick generator; UART_BAUD_MID_TICK_EN adds tick_mid
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int ACC_WIDTH       = 13,
  parameter int OVERSAMPLE_LOG2 = UART_OS_LOG2_DEFAULT,
  parameter int DEFAULT_INC     = UART_INC_100M_115200
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       inc_wr,
  input  logic [ACC_WIDTH-1:0]       inc_in,
  input  logic                       resync,
  output logic [ACC_WIDTH-1:0]       inc_out,
  output logic                       tick_os,
  output logic                       tick,
  output logic [OVERSAMPLE_LOG2-1:0] phase
`ifdef UART_BAUD_MID_TICK_EN
  ,
  output logic                       tick_mid
`endif
);

  logic [ACC_WIDTH:0]   acc;
  logic [ACC_WIDTH-1:0] inc;
  logic                 clear;
  logic                 phase_last;

  // Any of a rate write, a resync or a disable restarts timing from zero phase
  assign clear = inc_wr | resync | ~enable;

  // Active increment: only reset or an explicit write changes it
  always_ff @(posedge clock) begin
    if (reset) begin
      inc <= ACC_WIDTH'(DEFAULT_INC);
    end else if (inc_wr) begin
      inc <= inc_in;
    end
  end

  // Phase accumulator: the top bit holds the carry of the last step, which is the oversample tick
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc <= '0;
    end else begin
      acc <= {1'b0, acc[ACC_WIDTH-1:0]} + {1'b0, inc};
    end
  end

  assign tick_os = acc[ACC_WIDTH];
  assign inc_out = inc;

`ifdef UART_BAUD_MID_TICK_EN
  logic phase_mid;

  uart_tick_div #(
    .WIDTH (OVERSAMPLE_LOG2)
  ) u_tick_div (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .count_en (tick_os),
    .count    (phase),
    .terminal (phase_last),
    .mid      (phase_mid)
  );

  assign tick_mid = tick_os & phase_mid;
`else
  uart_tick_div #(
    .WIDTH (OVERSAMPLE_LOG2)
  ) u_tick_div (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .count_en (tick_os),
    .count    (phase),
    .terminal (phase_last),
    .mid      ()
  );
`endif

  assign tick = tick_os & phase_last;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - self-checking bench for uart_baud_gen
module tb_uart_baud_gen;
  import uart_pkg::*;

  localparam int W = 13;
  localparam int L = 4;
  localparam int NPH = 1 << L;

  logic          clock = 1'b0;
  logic          reset, enable, inc_wr, resync;
  logic [W-1:0]  inc_in, inc_out;
  logic          tick_os, tick;
  uart_phase_t   phase;
`ifdef UART_BAUD_MID_TICK_EN
  logic          tick_mid;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state: enabled cycles since the last restart, and the active increment
  longint m_n   = 0;
  longint m_inc = UART_INC_100M_115200;

  always #5 clock = ~clock;

  uart_baud_gen #(
    .ACC_WIDTH       (W),
    .OVERSAMPLE_LOG2 (L),
    .DEFAULT_INC     (UART_INC_100M_115200)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .inc_wr   (inc_wr),
    .inc_in   (inc_in),
    .resync   (resync),
    .inc_out  (inc_out),
    .tick_os  (tick_os),
    .tick     (tick),
    .phase    (phase)
`ifdef UART_BAUD_MID_TICK_EN
    ,
    .tick_mid (tick_mid)
`endif
  );

  // Number of oversample ticks emitted after n steps: floor(n*inc / 2^W)
  function automatic longint os_total(input longint n);
    return (n * m_inc) >> W;
  endfunction

  function automatic logic exp_os();
    return (m_n > 0) && (os_total(m_n) != os_total(m_n - 1));
  endfunction

  function automatic int exp_phase();
    return (m_n > 0) ? int'(os_total(m_n - 1) % NPH) : 0;
  endfunction

  // One clock with the given inputs; the model follows the priority rules, outputs are sampled at negedge
  task automatic step(input logic rst, input logic en, input logic wr, input logic rs,
                      input logic [W-1:0] din);
    reset = rst; enable = en; inc_wr = wr; resync = rs; inc_in = din;
    @(posedge clock);
    if (rst) begin
      m_n = 0; m_inc = UART_INC_100M_115200;
    end else if (wr) begin
      m_n = 0; m_inc = longint'(din);
    end else if (rs || !en) begin
      m_n = 0;
    end else begin
      m_n++;
    end
    @(negedge clock);
  endtask

  task automatic run();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b1, W'($urandom_range(1, 8191)));
    checks++; if (inc_out !== W'(151)) begin failures++; $display("FAIL reset_inc_out got=%0d exp=151", inc_out); end
    checks++; if (tick_os !== 1'b0) begin failures++; $display("FAIL reset_tick_os got=%b exp=0", tick_os); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (phase !== '0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase); end
`ifdef UART_BAUD_MID_TICK_EN
    checks++; if (tick_mid !== 1'b0) begin failures++; $display("FAIL reset_tick_mid got=%b exp=0", tick_mid); end
`endif
  endtask

  task automatic test_default_rate();
    int first_os = 0, os_cnt = 0, tick_cnt = 0, os_at_tick = 0;
    int ph_at_tick = -1;
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int c = 1; c <= 8192; c++) begin
      run();
      if (tick_os === 1'b1) begin
        os_cnt++;
        if (first_os == 0) first_os = c;
      end
      if (tick === 1'b1) begin
        if (tick_cnt == 0) begin os_at_tick = os_cnt; ph_at_tick = int'(phase); end
        tick_cnt++;
      end
    end
    checks++; if (first_os != 55) begin failures++; $display("FAIL default_first_os got=%0d exp=55", first_os); end
    checks++; if (os_cnt != 151) begin failures++; $display("FAIL default_os_count got=%0d exp=151", os_cnt); end
    checks++; if (tick_cnt != 9) begin failures++; $display("FAIL default_tick_count got=%0d exp=9", tick_cnt); end
    checks++; if (os_at_tick != 16) begin failures++; $display("FAIL default_first_tick_os_index got=%0d exp=16", os_at_tick); end
    checks++; if (ph_at_tick != 15) begin failures++; $display("FAIL default_first_tick_phase got=%0d exp=15", ph_at_tick); end
  endtask

  task automatic test_rate_change();
    int first_os = 0;
    for (int c = 0; c < 300; c++) run();
    step(1'b0, 1'b1, 1'b1, 1'b0, W'(UART_INC_66M_115200));
    checks++; if (inc_out !== W'(453)) begin failures++; $display("FAIL rate_inc_out got=%0d exp=453", inc_out); end
    checks++; if (phase !== '0 || tick_os !== 1'b0) begin failures++; $display("FAIL rate_cleared phase=%0d tick_os=%b exp=0/0", phase, tick_os); end
    for (int c = 1; c <= 100 && first_os == 0; c++) begin
      run();
      if (tick_os === 1'b1) first_os = c;
    end
    checks++; if (first_os != 19) begin failures++; $display("FAIL rate_first_os got=%0d exp=19", first_os); end
  endtask

  task automatic test_resync();
    int guard = 0, os_cnt = 0;
    bit got_tick = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    while (phase !== uart_phase_t'(7) && guard < 2000) begin run(); guard++; end
    checks++; if (phase !== uart_phase_t'(7)) begin failures++; $display("FAIL resync_reach_phase7 got=%0d exp=7", phase); end
    step(1'b0, 1'b1, 1'b0, 1'b1, '0);
    checks++; if (phase !== '0) begin failures++; $display("FAIL resync_phase got=%0d exp=0", phase); end
    for (int c = 0; c < 20000 && !got_tick; c++) begin
      run();
      if (tick_os === 1'b1) os_cnt++;
      if (tick === 1'b1) got_tick = 1;
    end
    checks++; if (!got_tick || os_cnt != 16) begin failures++; $display("FAIL resync_tick_after_os got=%0d exp=16 (tick_seen=%0d)", os_cnt, got_tick); end
  endtask

  task automatic test_enable_gap();
    int bad = 0, first_os = 0;
    for (int c = 0; c < 200; c++) run();
    for (int c = 0; c < 100; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      if (tick_os !== 1'b0 || tick !== 1'b0 || phase !== '0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL gap_idle_cycles_active got=%0d exp=0", bad); end
    for (int c = 1; c <= 200 && first_os == 0; c++) begin
      run();
      if (tick_os === 1'b1) first_os = c;
    end
    checks++; if (first_os != 55) begin failures++; $display("FAIL gap_first_os got=%0d exp=55", first_os); end
    checks++; if (inc_out !== W'(151)) begin failures++; $display("FAIL gap_inc_retained got=%0d exp=151", inc_out); end
  endtask

  task automatic test_inc_extremes();
    int os_cnt = 0, ph_bad = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0, W'(0));
    for (int c = 0; c < 20000; c++) begin
      run();
      if (tick_os === 1'b1) os_cnt++;
      if (phase !== '0) ph_bad++;
    end
    checks++; if (os_cnt != 0) begin failures++; $display("FAIL inc0_os_count got=%0d exp=0", os_cnt); end
    checks++; if (ph_bad != 0) begin failures++; $display("FAIL inc0_phase_nonzero got=%0d exp=0", ph_bad); end
    os_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0, W'(8191));
    for (int c = 0; c < 8192; c++) begin
      run();
      if (tick_os === 1'b1) os_cnt++;
    end
    checks++; if (os_cnt != 8191) begin failures++; $display("FAIL incmax_os_count got=%0d exp=8191", os_cnt); end
  endtask

`ifdef UART_BAUD_MID_TICK_EN
  task automatic test_mid_tick();
    int mid_cnt = 0, bad_ph = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int c = 0; c < 8192; c++) begin
      run();
      if (tick_mid === 1'b1) begin
        mid_cnt++;
        if (phase !== uart_phase_t'(7) || tick_os !== 1'b1) bad_ph++;
      end
    end
    checks++; if (mid_cnt != 9) begin failures++; $display("FAIL mid_count got=%0d exp=9", mid_cnt); end
    checks++; if (bad_ph != 0) begin failures++; $display("FAIL mid_phase_misplaced got=%0d exp=0", bad_ph); end
  endtask
`endif

  task automatic test_random();
    int r;
    logic rst, en, wr, rs;
    logic [W-1:0] din;
    logic e_os, e_tick;
    int e_ph;
    for (int i = 0; i < 6000; i++) begin
      r   = int'($urandom_range(0, 999));
      rst = (r < 2);
      wr  = (r >= 2 && r < 14);
      rs  = (r >= 10 && r < 22);
      en  = !(r >= 22 && r < 50);
      case ($urandom_range(0, 5))
        0:       din = W'(0);
        1:       din = W'(8191);
        2:       din = W'($urandom_range(1, 40));
        default: din = W'($urandom_range(1, 8191));
      endcase
      step(rst, en, wr, rs, din);
      e_os   = exp_os();
      e_ph   = exp_phase();
      e_tick = e_os && (e_ph == NPH - 1);
      checks++;
      if (tick_os !== e_os || tick !== e_tick || phase !== uart_phase_t'(e_ph) || inc_out !== W'(m_inc)) begin
        failures++;
        if (failures < 20)
          $display("FAIL random_cycle%0d got os=%b tick=%b phase=%0d inc=%0d exp os=%b tick=%b phase=%0d inc=%0d",
                   i, tick_os, tick, phase, inc_out, e_os, e_tick, e_ph, m_inc);
      end
`ifdef UART_BAUD_MID_TICK_EN
      checks++;
      if (tick_mid !== (e_os && e_ph == NPH / 2 - 1)) begin
        failures++;
        if (failures < 20) $display("FAIL random_mid_cycle%0d got=%b", i, tick_mid);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_rate_change();
    test_resync();
    test_enable_gap();
    test_inc_extremes();
`ifdef UART_BAUD_MID_TICK_EN
    test_mid_tick();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
